// File: rtl/rob_multiport.sv
// Multi-port reorder buffer: one issue per cycle, CDB_PORTS result writebacks,
// up to COMMIT_W in-order retirements per cycle, and squash of younger entries.
module rob_multiport #(
  parameter int DEPTH     = 16,
  parameter int IDX_W     = $clog2(DEPTH),
  parameter int CDB_PORTS = 2,
  parameter int COMMIT_W  = 2
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       i_flush_all,
  input  logic                       i_squash,
  input  logic [IDX_W-1:0]           i_squash_tag,
  input  logic                       i_issue_valid,
  output logic                       o_issue_ready,
  input  logic [31:0]                i_issue_pc,
  input  logic [4:0]                 i_issue_rd,
  input  logic [1:0]                 i_issue_kind,
  input  logic                       i_issue_pred_taken,
  input  logic [31:0]                i_issue_imm_value,
  output logic [IDX_W-1:0]           o_issue_tag,
  input  logic [2*IDX_W-1:0]         i_rs_tag,
  output logic [2*32-1:0]            o_rs_value,
  output logic [1:0]                 o_rs_done,
  input  logic [CDB_PORTS-1:0]       i_cdb_valid,
  input  logic [CDB_PORTS*IDX_W-1:0] i_cdb_tag,
  input  logic [CDB_PORTS*32-1:0]    i_cdb_data,
  output logic [COMMIT_W-1:0]        o_commit_valid,
  output logic [COMMIT_W*IDX_W-1:0]  o_commit_tag,
  output logic [COMMIT_W*32-1:0]     o_commit_pc,
  output logic [COMMIT_W*5-1:0]      o_commit_rd,
  output logic [COMMIT_W*32-1:0]     o_commit_value,
  output logic [COMMIT_W*2-1:0]      o_commit_kind,
  output logic [COMMIT_W-1:0]        o_commit_mispredict,
  input  logic [COMMIT_W-1:0]        i_commit_pop,
  output logic [IDX_W:0]             o_count,
  output logic                       o_full,
  output logic                       o_empty
);
  typedef logic [IDX_W-1:0] idx_t;
  localparam logic [IDX_W:0] DEPTH_C = (IDX_W+1)'(DEPTH);
  localparam logic [IDX_W:0] ONE_C   = (IDX_W+1)'(1);

  logic [DEPTH-1:0] ent_valid;
  logic [DEPTH-1:0] ent_done;
  logic [DEPTH-1:0] ent_misp;
  logic [DEPTH-1:0] ent_pred;
  logic [1:0]       ent_kind  [DEPTH];
  logic [31:0]      ent_pc    [DEPTH];
  logic [4:0]       ent_rd    [DEPTH];
  logic [31:0]      ent_value [DEPTH];

  idx_t           head;
  idx_t           tail;
  logic [IDX_W:0] count;

  logic [CDB_PORTS-1:0] cdb_ok;
  idx_t                 cdb_idx [CDB_PORTS];
  logic                 squash_ok;
  idx_t                 squash_age;
  logic [DEPTH-1:0]     kill;
  logic                 issue_fire;
  idx_t                 slot_idx [COMMIT_W];
  logic [IDX_W:0]       pop_n;
  idx_t                 rs_idx [2];
  logic                 chain;
  logic                 run;

  assign o_count       = count;
  assign o_full        = (count == DEPTH_C);
  assign o_empty       = (count == '0);
  assign o_issue_ready = !o_full;
  assign o_issue_tag   = tail;

  // A CDB write lands only on a live ALU/branch entry still waiting for its result.
  always_comb begin
    for (int p = 0; p < CDB_PORTS; p++) begin
      cdb_idx[p] = i_cdb_tag[p*IDX_W +: IDX_W];
      cdb_ok[p]  = i_cdb_valid[p] && ent_valid[cdb_idx[p]] &&
                   !ent_done[cdb_idx[p]] && !ent_kind[cdb_idx[p]][1];
    end
  end

  // Squash kills every live entry older-in-position (younger in program order) than the tag.
  always_comb begin
    squash_ok  = i_squash && ent_valid[i_squash_tag];
    squash_age = i_squash_tag - head;
    kill       = '0;
    for (int i = 0; i < DEPTH; i++)
      kill[i] = squash_ok && ent_valid[i] && (idx_t'(idx_t'(i) - head) > squash_age);
  end

  assign issue_fire = i_issue_valid && !o_full && !squash_ok;

  always_comb begin
    chain               = 1'b1;
    o_commit_valid      = '0;
    o_commit_tag        = '0;
    o_commit_pc         = '0;
    o_commit_rd         = '0;
    o_commit_value      = '0;
    o_commit_kind       = '0;
    o_commit_mispredict = '0;
    for (int k = 0; k < COMMIT_W; k++) begin
      slot_idx[k]                        = head + idx_t'(k);
      o_commit_valid[k]                  = chain && ent_valid[slot_idx[k]] && ent_done[slot_idx[k]];
      chain                              = o_commit_valid[k] && !ent_misp[slot_idx[k]];
      o_commit_tag[k*IDX_W +: IDX_W]     = slot_idx[k];
      o_commit_pc[k*32 +: 32]            = ent_pc[slot_idx[k]];
      o_commit_rd[k*5 +: 5]              = ent_rd[slot_idx[k]];
      o_commit_value[k*32 +: 32]         = ent_value[slot_idx[k]];
      o_commit_kind[k*2 +: 2]            = ent_kind[slot_idx[k]];
      o_commit_mispredict[k]             = ent_misp[slot_idx[k]];
    end
  end

  always_comb begin
    run   = 1'b1;
    pop_n = '0;
    for (int k = 0; k < COMMIT_W; k++) begin
      run = run && i_commit_pop[k] && o_commit_valid[k];
      if (run)
        pop_n = pop_n + ONE_C;
    end
  end

  // Operand lookup; the lowest-index CDB hit wins the bypass.
  always_comb begin
    o_rs_value = '0;
    o_rs_done  = '0;
    for (int r = 0; r < 2; r++) begin
      rs_idx[r]               = i_rs_tag[r*IDX_W +: IDX_W];
      o_rs_value[r*32 +: 32]  = ent_value[rs_idx[r]];
      o_rs_done[r]            = ent_done[rs_idx[r]];
      if (!ent_done[rs_idx[r]]) begin
        for (int p = CDB_PORTS-1; p >= 0; p--) begin
          if (cdb_ok[p] && (cdb_idx[p] == rs_idx[r])) begin
            o_rs_value[r*32 +: 32] = i_cdb_data[p*32 +: 32];
            o_rs_done[r]           = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ent_valid <= '0;
      ent_done  <= '0;
      ent_misp  <= '0;
      head      <= '0;
      tail      <= '0;
      count     <= '0;
    end else if (i_flush_all) begin
      ent_valid <= '0;
      ent_done  <= '0;
      ent_misp  <= '0;
      head      <= '0;
      tail      <= '0;
      count     <= '0;
    end else begin
      for (int k = 0; k < COMMIT_W; k++) begin
        if ((IDX_W+1)'(k) < pop_n) begin
          ent_valid[slot_idx[k]] <= 1'b0;
          ent_done[slot_idx[k]]  <= 1'b0;
        end
      end
      // Ascending port order: the highest port's write is the one that sticks.
      for (int p = 0; p < CDB_PORTS; p++) begin
        if (cdb_ok[p] && !kill[cdb_idx[p]]) begin
          ent_done[cdb_idx[p]] <= 1'b1;
          ent_misp[cdb_idx[p]] <= (ent_kind[cdb_idx[p]] == 2'b01) &&
                                  (ent_pred[cdb_idx[p]] ^ i_cdb_data[p*32]);
        end
      end
      for (int i = 0; i < DEPTH; i++) begin
        if (kill[i]) begin
          ent_valid[i] <= 1'b0;
          ent_done[i]  <= 1'b0;
        end
      end
      if (issue_fire) begin
        ent_valid[tail] <= 1'b1;
        ent_done[tail]  <= i_issue_kind[1];
        ent_misp[tail]  <= 1'b0;
      end
      head <= head + idx_t'(pop_n);
      if (squash_ok) begin
        tail  <= i_squash_tag + 1'b1;
        count <= {1'b0, squash_age} + ONE_C - pop_n;
      end else begin
        tail  <= tail + idx_t'(issue_fire);
        count <= count + (IDX_W+1)'(issue_fire) - pop_n;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (issue_fire) begin
      ent_pc[tail]    <= i_issue_pc;
      ent_rd[tail]    <= i_issue_rd;
      ent_kind[tail]  <= i_issue_kind;
      ent_pred[tail]  <= i_issue_pred_taken;
      ent_value[tail] <= (i_issue_kind == 2'b10) ? i_issue_imm_value : 32'd0;
    end
    for (int p = 0; p < CDB_PORTS; p++)
      if (cdb_ok[p] && !kill[cdb_idx[p]])
        ent_value[cdb_idx[p]] <= i_cdb_data[p*32 +: 32];
  end

endmodule

// File: tb/tb_rob_multiport.sv
// Bench for rob_multiport: directed scenarios plus random traffic, all outputs
// compared each cycle against a queue-based model of the buffer.
module tb_rob_multiport;
  localparam int DEPTH = 16;
  localparam int IDX_W = 4;
  localparam int CP    = 2;
  localparam int CW    = 2;

  logic                 clk = 1'b0;
  logic                 rstn = 1'b0;
  logic                 i_flush_all, i_squash;
  logic [IDX_W-1:0]     i_squash_tag;
  logic                 i_issue_valid, o_issue_ready;
  logic [31:0]          i_issue_pc, i_issue_imm_value;
  logic [4:0]           i_issue_rd;
  logic [1:0]           i_issue_kind;
  logic                 i_issue_pred_taken;
  logic [IDX_W-1:0]     o_issue_tag;
  logic [2*IDX_W-1:0]   i_rs_tag;
  logic [63:0]          o_rs_value;
  logic [1:0]           o_rs_done;
  logic [CP-1:0]        i_cdb_valid;
  logic [CP*IDX_W-1:0]  i_cdb_tag;
  logic [CP*32-1:0]     i_cdb_data;
  logic [CW-1:0]        o_commit_valid, o_commit_mispredict, i_commit_pop;
  logic [CW*IDX_W-1:0]  o_commit_tag;
  logic [CW*32-1:0]     o_commit_pc, o_commit_value;
  logic [CW*5-1:0]      o_commit_rd;
  logic [CW*2-1:0]      o_commit_kind;
  logic [IDX_W:0]       o_count;
  logic                 o_full, o_empty;

  rob_multiport #(.DEPTH(DEPTH), .IDX_W(IDX_W), .CDB_PORTS(CP), .COMMIT_W(CW)) dut (
    .clk(clk), .rstn(rstn), .i_flush_all(i_flush_all), .i_squash(i_squash),
    .i_squash_tag(i_squash_tag), .i_issue_valid(i_issue_valid), .o_issue_ready(o_issue_ready),
    .i_issue_pc(i_issue_pc), .i_issue_rd(i_issue_rd), .i_issue_kind(i_issue_kind),
    .i_issue_pred_taken(i_issue_pred_taken), .i_issue_imm_value(i_issue_imm_value),
    .o_issue_tag(o_issue_tag), .i_rs_tag(i_rs_tag), .o_rs_value(o_rs_value), .o_rs_done(o_rs_done),
    .i_cdb_valid(i_cdb_valid), .i_cdb_tag(i_cdb_tag), .i_cdb_data(i_cdb_data),
    .o_commit_valid(o_commit_valid), .o_commit_tag(o_commit_tag), .o_commit_pc(o_commit_pc),
    .o_commit_rd(o_commit_rd), .o_commit_value(o_commit_value), .o_commit_kind(o_commit_kind),
    .o_commit_mispredict(o_commit_mispredict), .i_commit_pop(i_commit_pop),
    .o_count(o_count), .o_full(o_full), .o_empty(o_empty)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [1:0]  kind;
    logic        pred;
    logic        done;
    logic [31:0] value;
    logic        misp;
  } ent_t;

  ent_t q[$];
  int   head_tag = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int find(input int tag);
    int d;
    d = (tag - head_tag + DEPTH) % DEPTH;
    return (d < q.size()) ? d : -1;
  endfunction

  function automatic bit cdb_hit(input int p);
    int i;
    i = find(int'(i_cdb_tag[p*IDX_W +: IDX_W]));
    if (!i_cdb_valid[p] || i < 0) return 1'b0;
    return !q[i].done && !q[i].kind[1];
  endfunction

  // Slot k retires if entries 0..k are done and none before k mispredicted.
  function automatic bit slot_ok(input int k);
    if (k >= q.size()) return 1'b0;
    for (int j = 0; j <= k; j++) begin
      if (!q[j].done) return 1'b0;
      if (j < k && q[j].misp) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic int pop_count();
    int  n;
    bit  go;
    n  = 0;
    go = 1'b1;
    for (int k = 0; k < CW; k++) begin
      go = go && i_commit_pop[k] && slot_ok(k);
      if (go) n++;
    end
    return n;
  endfunction

  task automatic compare_all();
    int sz;
    int i;
    int t;
    bit ed;
    logic [31:0] ev;
    sz = q.size();
    check("count", o_count, sz);
    check("full", o_full, sz == DEPTH);
    check("empty", o_empty, sz == 0);
    check("ready", o_issue_ready, sz != DEPTH);
    check("issue_tag", o_issue_tag, (head_tag + sz) % DEPTH);
    for (int k = 0; k < CW; k++) begin
      check("commit_valid", o_commit_valid[k], slot_ok(k));
      if (slot_ok(k)) begin
        check("commit_tag", o_commit_tag[k*IDX_W +: IDX_W], (head_tag + k) % DEPTH);
        check("commit_pc", o_commit_pc[k*32 +: 32], q[k].pc);
        check("commit_rd", o_commit_rd[k*5 +: 5], q[k].rd);
        check("commit_value", o_commit_value[k*32 +: 32], q[k].value);
        check("commit_kind", o_commit_kind[k*2 +: 2], q[k].kind);
        check("commit_misp", o_commit_mispredict[k], q[k].misp);
      end
    end
    for (int r = 0; r < 2; r++) begin
      t  = int'(i_rs_tag[r*IDX_W +: IDX_W]);
      i  = find(t);
      ed = 1'b0;
      ev = '0;
      if (i >= 0 && q[i].done) begin
        ed = 1'b1;
        ev = q[i].value;
      end else begin
        for (int p = 0; p < CP; p++) begin
          if (!ed && cdb_hit(p) && int'(i_cdb_tag[p*IDX_W +: IDX_W]) == t) begin
            ed = 1'b1;
            ev = i_cdb_data[p*32 +: 32];
          end
        end
      end
      check("rs_done", o_rs_done[r], ed);
      if (ed) check("rs_value", o_rs_value[r*32 +: 32], ev);
    end
  endtask

  task automatic model_update();
    bit ok [CP];
    int n;
    int st;
    int i;
    ent_t e;
    if (i_flush_all) begin
      q.delete();
      head_tag = 0;
      return;
    end
    for (int p = 0; p < CP; p++) ok[p] = cdb_hit(p);
    n  = pop_count();
    st = i_squash ? find(int'(i_squash_tag)) : -1;
    for (int p = 0; p < CP; p++) begin
      if (ok[p]) begin
        i = find(int'(i_cdb_tag[p*IDX_W +: IDX_W]));
        if (st < 0 || i <= st) begin
          q[i].done  = 1'b1;
          q[i].value = i_cdb_data[p*32 +: 32];
          q[i].misp  = (q[i].kind == 2'b01) && (q[i].pred ^ i_cdb_data[p*32]);
        end
      end
    end
    if (st >= 0) begin
      while (q.size() > st + 1) void'(q.pop_back());
    end else if (i_issue_valid && q.size() < DEPTH) begin
      e.pc    = i_issue_pc;
      e.rd    = i_issue_rd;
      e.kind  = i_issue_kind;
      e.pred  = i_issue_pred_taken;
      e.done  = i_issue_kind[1];
      e.value = (i_issue_kind == 2'b10) ? i_issue_imm_value : 32'd0;
      e.misp  = 1'b0;
      q.push_back(e);
    end
    for (int k = 0; k < n; k++) void'(q.pop_front());
    head_tag = (head_tag + n) % DEPTH;
  endtask

  task automatic step();
    #1;
    compare_all();
    model_update();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clr();
    i_flush_all = 0; i_squash = 0; i_squash_tag = '0;
    i_issue_valid = 0; i_issue_pc = '0; i_issue_rd = '0; i_issue_kind = '0;
    i_issue_pred_taken = 0; i_issue_imm_value = '0; i_rs_tag = '0;
    i_cdb_valid = '0; i_cdb_tag = '0; i_cdb_data = '0; i_commit_pop = '0;
  endtask

  task automatic issue(input logic [1:0] kind, input logic pred);
    clr();
    i_issue_valid = 1; i_issue_kind = kind; i_issue_pred_taken = pred;
    i_issue_pc = $urandom; i_issue_rd = 5'($urandom); i_issue_imm_value = $urandom;
    step();
  endtask

  task automatic flush();
    clr();
    i_flush_all = 1;
    i_issue_valid = 1;
    step();
    clr();
  endtask

  function automatic int pick_tag();
    if (q.size() > 0 && ($urandom % 8) != 0)
      return (head_tag + int'($urandom % q.size())) % DEPTH;
    return int'($urandom % DEPTH);
  endfunction

  task automatic rand_inputs();
    clr();
    i_flush_all        = ($urandom % 200) == 0;
    i_issue_valid      = ($urandom % 10) < 7;
    i_issue_kind       = 2'($urandom);
    i_issue_pred_taken = 1'($urandom);
    i_issue_pc         = $urandom;
    i_issue_rd         = 5'($urandom);
    i_issue_imm_value  = $urandom;
    for (int p = 0; p < CP; p++) begin
      i_cdb_valid[p]              = ($urandom % 10) < 6;
      i_cdb_tag[p*IDX_W +: IDX_W] = IDX_W'(pick_tag());
      i_cdb_data[p*32 +: 32]      = $urandom;
    end
    for (int r = 0; r < 2; r++) i_rs_tag[r*IDX_W +: IDX_W] = IDX_W'(pick_tag());
    i_squash     = ($urandom % 25) == 0;
    i_squash_tag = IDX_W'(pick_tag());
    i_commit_pop = i_squash ? 2'b00 : ((($urandom % 4) != 0) ? 2'b11 : 2'($urandom));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    clr();
    #2;
    check("rst_empty", o_empty, 1);
    check("rst_full", o_full, 0);
    check("rst_ready", o_issue_ready, 1);
    check("rst_commit_valid", o_commit_valid, 0);
    check("rst_issue_tag", o_issue_tag, 0);
    check("rst_count", o_count, 0);
    @(negedge clk);
    rstn = 1;

    // Fill to full, then an ignored 17th issue.
    for (int i = 0; i < 16; i++) begin
      clr();
      i_issue_valid = 1;
      #1;
      check("fill_tag", o_issue_tag, i);
      step();
    end
    clr();
    #1;
    check("fill_full", o_full, 1);
    check("fill_ready", o_issue_ready, 0);
    check("fill_count", o_count, 16);
    i_issue_valid = 1;
    step();
    clr();
    #1;
    check("over_count", o_count, 16);
    check("over_tail", o_issue_tag, 0);
    flush();

    // Out-of-order CDB completion, then a double retire.
    issue(2'b00, 0);
    issue(2'b00, 0);
    clr(); i_cdb_valid = 2'b01; i_cdb_tag[3:0] = 4'd1; i_cdb_data[31:0] = 32'd7;
    step();
    clr(); i_cdb_valid = 2'b10; i_cdb_tag[7:4] = 4'd0; i_cdb_data[63:32] = 32'd3;
    step();
    clr();
    #1;
    check("ooo_valid", o_commit_valid, 2'b11);
    check("ooo_value0", o_commit_value[31:0], 3);
    check("ooo_value1", o_commit_value[63:32], 7);
    i_commit_pop = 2'b11;
    step();
    clr();
    #1;
    check("pop_count", o_count, 0);
    check("pop_head", o_commit_tag[3:0], 2);

    // Bypass of a same-cycle CDB result into operand lookup.
    issue(2'b00, 0);
    issue(2'b00, 0);
    clr(); i_issue_valid = 1;
    #1;
    check("byp_tag", o_issue_tag, 4);
    step();
    clr(); i_cdb_valid = 2'b10; i_cdb_tag[7:4] = 4'd4; i_cdb_data[63:32] = 32'hAB; i_rs_tag[3:0] = 4'd4;
    #1;
    check("byp_done", o_rs_done[0], 1);
    check("byp_value", o_rs_value[31:0], 32'hAB);
    step();
    clr(); i_rs_tag[3:0] = 4'd4;
    #1;
    check("byp_done_after", o_rs_done[0], 1);
    step();
    flush();

    // Mispredicted branch closes its commit group.
    issue(2'b01, 1);
    issue(2'b00, 0);
    clr(); i_cdb_valid = 2'b11; i_cdb_tag = {4'd1, 4'd0}; i_cdb_data = {32'd5, 32'd0};
    step();
    clr();
    #1;
    check("misp_valid", o_commit_valid, 2'b01);
    check("misp_flag", o_commit_mispredict[0], 1);
    i_commit_pop = 2'b11;
    step();
    clr();
    #1;
    check("misp_count", o_count, 1);
    check("misp_head", o_commit_tag[3:0], 1);
    flush();

    // Partial squash with a same-cycle CDB and issue that must be dropped.
    for (int i = 0; i < 6; i++) issue(2'b00, 0);
    clr(); i_squash = 1; i_squash_tag = 4'd2; i_issue_valid = 1;
    i_cdb_valid = 2'b01; i_cdb_tag[3:0] = 4'd4; i_cdb_data[31:0] = 32'd9;
    step();
    clr(); i_rs_tag[3:0] = 4'd4;
    #1;
    check("sq_count", o_count, 3);
    check("sq_tail", o_issue_tag, 3);
    check("sq_cdb_dropped", o_rs_done[0], 0);
    i_issue_valid = 1;
    step();
    flush();

    // Stream 20 entries through the buffer so the tags wrap.
    for (int i = 0; i < 20; i++) begin
      clr();
      i_issue_valid = 1; i_issue_pc = 32'(i * 4);
      if (i > 0) begin
        i_cdb_valid = 2'b01; i_cdb_tag[3:0] = 4'((i - 1) % DEPTH); i_cdb_data[31:0] = 32'(100 + i);
      end
      i_commit_pop = 2'b11;
      #1;
      check("wrap_tag", o_issue_tag, i % DEPTH);
      step();
    end
    clr(); i_cdb_valid = 2'b01; i_cdb_tag[3:0] = 4'd3; i_cdb_data[31:0] = 32'd120; i_commit_pop = 2'b11;
    step();
    clr(); i_commit_pop = 2'b11;
    step();
    clr();
    #1;
    check("wrap_empty", o_empty, 1);
    check("wrap_count", o_count, 0);

    // Random traffic with one asynchronous reset in the middle.
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) begin
        clr();
        rstn = 0;
        #1;
        q.delete();
        head_tag = 0;
        check("arst_count", o_count, 0);
        check("arst_empty", o_empty, 1);
        check("arst_commit_valid", o_commit_valid, 0);
        check("arst_issue_tag", o_issue_tag, 0);
        @(posedge clk);
        @(negedge clk);
        rstn = 1;
      end
      rand_inputs();
      step();
    end
    clr();
    #1;
    compare_all();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
